// File: rtl/mario_pkg.sv
// Shared constants, tile codes and types for Mario's horizontal mover.
// Tile maps are packed [row][col] so they pass cleanly through ports.
package mario_pkg;

  typedef logic [7:0] tile_t;
  typedef tile_t [0:11][0:16] tile_map_t;

  localparam tile_t BDR = 8'd0;
  localparam tile_t SKY = 8'd1;
  localparam tile_t BLK = 8'd2;
  localparam tile_t GND = 8'd3;
  localparam tile_t TKN = 8'd4;
  localparam tile_t CK1 = 8'd5;
  localparam tile_t CK2 = 8'd6;

  localparam int CHARACTER_WIDTH = 42;
  localparam int SCREEN_WIDTH    = 640;
  localparam int BLOCK_WIDTH     = 40;
  localparam int MAP_LAST_ROW    = 11;
  localparam int MAP_LAST_COL    = 16;
  localparam int START_X         = 40;
  localparam int SLOW_PERIOD     = 4;
  localparam int FAST_PERIOD     = 2;
  localparam int ACCEL_STEPS     = 8;

  typedef enum logic [1:0] {
    ST_RESET        = 2'd0,
    ST_STANDING     = 2'd1,
    ST_MOVING_LEFT  = 2'd2,
    ST_MOVING_RIGHT = 2'd3
  } move_state_e;

  function automatic logic is_solid(input tile_t tile);
    case (tile)
      BDR, BLK, GND, CK1, CK2: is_solid = 1'b1;
      default:                 is_solid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mario_left_right_mover_if.sv
// Button, tile-map and position bundle between the horizontal mover and its
// neighbours (vertical mover, renderer, input logic).
interface mario_left_right_mover_if;
  import mario_pkg::*;

  logic               left;
  logic               right;
  tile_map_t          background;
  logic signed [31:0] mario_y;
  logic signed [31:0] mario_x;
  logic               facing_left;
  logic               moving;
  logic               blocked;

  modport master (
    output left, right, background, mario_y,
    input  mario_x, facing_left, moving, blocked
  );

  modport slave (
    input  left, right, background, mario_y,
    output mario_x, facing_left, moving, blocked
  );

endinterface

// File: rtl/mario_side_probe.sv
// Looks one pixel past Mario's leading edge and reports whether either the
// top or bottom probed tile in that column is solid.
module mario_side_probe
  import mario_pkg::*;
(
  input  tile_map_t          background_i,
  input  logic signed [31:0] mario_x_i,
  input  logic signed [31:0] mario_y_i,
  input  logic               side_i,
  output logic               solid_ahead_o
);

  logic [3:0] row_top;
  logic [3:0] row_bot;
  logic [4:0] col;

  function automatic logic [3:0] clamp_row(input logic signed [31:0] pix);
    int r;
    r = pix / BLOCK_WIDTH;
    if (pix < 32'sd0) begin
      clamp_row = 4'd0;
    end else if (r > MAP_LAST_ROW) begin
      clamp_row = 4'(MAP_LAST_ROW);
    end else begin
      clamp_row = r[3:0];
    end
  endfunction

  function automatic logic [4:0] clamp_col(input logic signed [31:0] pix);
    int c;
    c = pix / BLOCK_WIDTH;
    if (pix < 32'sd0) begin
      clamp_col = 5'd0;
    end else if (c > MAP_LAST_COL) begin
      clamp_col = 5'(MAP_LAST_COL);
    end else begin
      clamp_col = c[4:0];
    end
  endfunction

  // Probe column and clamped rows; the left column is never formed at x=0.
  always_comb begin
    row_top = clamp_row(mario_y_i + 32'sd1);
    row_bot = clamp_row(mario_y_i + 32'(CHARACTER_WIDTH - 1));
    col     = 5'd0;
    if (side_i) begin
      if (mario_x_i > 32'sd0) begin
        col = clamp_col(mario_x_i - 32'sd1);
      end else begin
        col = 5'd0;
      end
    end else begin
      col = clamp_col(mario_x_i + 32'(CHARACTER_WIDTH));
    end
    solid_ahead_o = is_solid(background_i[row_top][col]) |
                    is_solid(background_i[row_bot][col]);
  end

endmodule

// File: rtl/mario_left_right_mover.sv
// Horizontal mover: owns mario_x, steps one pixel per due tick from the
// buttons, accelerating from a slow to a fast rate and stopping at walls.
module mario_left_right_mover
  import mario_pkg::*;
(
  input  logic                    movement_clock,
  input  logic                    reset,
  mario_left_right_mover_if.slave mv
);

  localparam logic [2:0]         SLOW_P    = 3'(SLOW_PERIOD);
  localparam logic [2:0]         FAST_P    = 3'(FAST_PERIOD);
  localparam logic [3:0]         ACCEL_CNT = 4'(ACCEL_STEPS);
  localparam logic signed [31:0] X_START   = 32'(START_X);
  localparam logic signed [31:0] X_MAX     = 32'(SCREEN_WIDTH - CHARACTER_WIDTH);

  move_state_e        state_q, state_d;
  logic [2:0]         div_cnt_q, div_cnt_d;
  logic [3:0]         step_cnt_q, step_cnt_d;
  logic signed [31:0] mario_x_q, mario_x_d;
  logic               facing_left_q, facing_left_d;
  logic               moving_q, moving_d;
  logic               blocked_q, blocked_d;

  logic       dir_l;
  logic       dir_r;
  logic [2:0] period;
  logic       step_due;
  logic       probe_left;
  logic       solid_ahead;

  assign probe_left = (state_q == ST_MOVING_LEFT);

  mario_side_probe u_probe (
    .background_i  (mv.background),
    .mario_x_i     (mario_x_q),
    .mario_y_i     (mv.mario_y),
    .side_i        (probe_left),
    .solid_ahead_o (solid_ahead)
  );

  // Next-state, divider, step counter and position update.
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    step_cnt_d    = step_cnt_q;
    mario_x_d     = mario_x_q;
    facing_left_d = facing_left_q;
    blocked_d     = 1'b0;

    dir_l    = mv.left & ~mv.right;
    dir_r    = mv.right & ~mv.left;
    period   = (step_cnt_q >= ACCEL_CNT) ? FAST_P : SLOW_P;
    step_due = (div_cnt_q == (period - 3'd1));

    case (state_q)
      ST_RESET: begin
        state_d = ST_STANDING;
      end
      ST_STANDING: begin
        if (dir_r) begin
          state_d       = ST_MOVING_RIGHT;
          div_cnt_d     = 3'd0;
          step_cnt_d    = 4'd0;
          facing_left_d = 1'b0;
        end else if (dir_l) begin
          state_d       = ST_MOVING_LEFT;
          div_cnt_d     = 3'd0;
          step_cnt_d    = 4'd0;
          facing_left_d = 1'b1;
        end else begin
          state_d = ST_STANDING;
        end
      end
      ST_MOVING_RIGHT, ST_MOVING_LEFT: begin
        if ((state_q == ST_MOVING_RIGHT) ? !dir_r : !dir_l) begin
          // Release or reversal always lands in STANDING for one tick.
          state_d = ST_STANDING;
        end else if (step_due) begin
          div_cnt_d = 3'd0;
          if (solid_ahead ||
              ((state_q == ST_MOVING_RIGHT) ? (mario_x_q >= X_MAX) : (mario_x_q <= 32'sd0))) begin
            step_cnt_d = 4'd0;
            blocked_d  = 1'b1;
          end else begin
            mario_x_d  = (state_q == ST_MOVING_RIGHT) ? (mario_x_q + 32'sd1) : (mario_x_q - 32'sd1);
            step_cnt_d = (step_cnt_q >= ACCEL_CNT) ? ACCEL_CNT : (step_cnt_q + 4'd1);
          end
        end else begin
          div_cnt_d = div_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    moving_d = (state_d == ST_MOVING_LEFT) || (state_d == ST_MOVING_RIGHT);
  end

  // State and output registers.
  always_ff @(posedge movement_clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RESET;
      div_cnt_q     <= 3'd0;
      step_cnt_q    <= 4'd0;
      mario_x_q     <= X_START;
      facing_left_q <= 1'b0;
      moving_q      <= 1'b0;
      blocked_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      step_cnt_q    <= step_cnt_d;
      mario_x_q     <= mario_x_d;
      facing_left_q <= facing_left_d;
      moving_q      <= moving_d;
      blocked_q     <= blocked_d;
    end
  end

  assign mv.mario_x     = mario_x_q;
  assign mv.facing_left = facing_left_q;
  assign mv.moving      = moving_q;
  assign mv.blocked     = blocked_q;

endmodule

// File: tb/tb_mario_left_right_mover.sv
// Directed bench for the horizontal mover: a schedule-based model checked
// every cycle, plus hand-computed positions and blocked pulses.
module tb_mario_left_right_mover;
  import mario_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: standing/right/left as 0/+1/-1, -2 for the post-reset tick.
  int m_mode  = -2;
  int m_x     = 40;
  int m_face  = 0;
  int m_mov   = 0;
  int m_blk   = 0;
  int m_steps = 0;
  int m_cyc   = 0;
  int m_due   = 0;

  mario_left_right_mover_if mv_if ();

  mario_left_right_mover dut (
    .movement_clock (clk),
    .reset          (rst_n),
    .mv             (mv_if)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit tile_solid(input int t);
    return (t == 0) || (t == 2) || (t == 3) || (t == 5) || (t == 6);
  endfunction

  function automatic bit m_refused(input int x, input int y, input int dir);
    int col, r0, r1;
    if (dir > 0) begin
      if (x >= 640 - 42) return 1'b1;
      col = (x + 42) / 40;
    end else begin
      if (x <= 0) return 1'b1;
      col = (x - 1) / 40;
    end
    r0 = (y + 1) / 40;
    r1 = (y + 41) / 40;
    if (r0 > 11) r0 = 11;
    if (r1 > 11) r1 = 11;
    return tile_solid(int'(mv_if.background[r0][col])) || tile_solid(int'(mv_if.background[r1][col]));
  endfunction

  // Model: each move has an absolute schedule of due ticks.
  initial forever begin
    int want;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = -2; m_x = 40; m_face = 0; m_mov = 0; m_blk = 0; m_steps = 0; m_cyc = 0; m_due = 0;
    end else begin
      m_cyc++;
      m_blk = 0;
      want = (mv_if.right && !mv_if.left) ? 1 : ((mv_if.left && !mv_if.right) ? -1 : 0);
      if (m_mode == -2) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (want != 0) begin
          m_mode = want; m_steps = 0; m_due = m_cyc + 4; m_face = (want < 0) ? 1 : 0;
        end
      end else if (want != m_mode) begin
        m_mode = 0;
      end else if (m_cyc == m_due) begin
        if (m_refused(m_x, int'(mv_if.mario_y), m_mode)) begin
          m_blk = 1; m_steps = 0;
        end else begin
          m_x += m_mode;
          if (m_steps < 8) m_steps++;
        end
        m_due = m_cyc + ((m_steps >= 8) ? 2 : 4);
      end
      m_mov = (m_mode == 1 || m_mode == -1) ? 1 : 0;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("x_model",      int'(mv_if.mario_x), m_x);
    chk("facing_model", int'(mv_if.facing_left), m_face);
    chk("moving_model", int'(mv_if.moving), m_mov);
    chk("blocked_model", int'(mv_if.blocked), m_blk);
  end

  task automatic wait_x(input int target, input int budget, input string nm);
    int n = 0;
    while (int'(mv_if.mario_x) != target && n < budget) begin
      edges(1);
      n++;
    end
    chk(nm, int'(mv_if.mario_x), target);
  endtask

  task automatic wait_blk(input int budget, input string nm);
    int n = 0;
    while (mv_if.blocked !== 1'b1 && n < budget) begin
      edges(1);
      n++;
    end
    chk(nm, int'(mv_if.blocked), 1);
  endtask

  initial begin
    mv_if.left    = 1'b0;
    mv_if.right   = 1'b0;
    mv_if.mario_y = 32'sd360;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        mv_if.background[r][c] = SKY;

    edges(2);
    chk("rst_x", int'(mv_if.mario_x), 40);
    chk("rst_facing", int'(mv_if.facing_left), 0);
    chk("rst_moving", int'(mv_if.moving), 0);
    chk("rst_blocked", int'(mv_if.blocked), 0);

    // Acceleration on an open map: press seen at edge k.
    rst_n = 1'b1;
    edges(1);
    mv_if.right = 1'b1;
    edges(1);
    chk("enter_moving", int'(mv_if.moving), 1);
    edges(3);
    chk("x_k3", int'(mv_if.mario_x), 40);
    edges(1);
    chk("x_k4", int'(mv_if.mario_x), 41);
    edges(28);
    chk("x_k32", int'(mv_if.mario_x), 48);
    edges(8);
    chk("x_k40", int'(mv_if.mario_x), 52);

    // Asynchronous reset mid-move.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x", int'(mv_if.mario_x), 40);
    chk("async_rst_moving", int'(mv_if.moving), 0);
    mv_if.right = 1'b0;
    edges(1);
    rst_n = 1'b1;
    edges(1);

    // Brick wall in column 3 rows 9-10; token in the path is passable.
    mv_if.background[9][3]  = BLK;
    mv_if.background[10][3] = BLK;
    mv_if.background[10][1] = TKN;
    mv_if.right = 1'b1;
    edges(1);
    edges(92);
    chk("wall_x_k92", int'(mv_if.mario_x), 78);
    chk("wall_noblk_k92", int'(mv_if.blocked), 0);
    edges(2);
    chk("wall_blk_k94", int'(mv_if.blocked), 1);
    edges(1);
    chk("wall_blk_k95", int'(mv_if.blocked), 0);
    edges(3);
    chk("wall_blk_k98", int'(mv_if.blocked), 1);
    edges(4);
    chk("wall_blk_k102", int'(mv_if.blocked), 1);
    chk("wall_x_k102", int'(mv_if.mario_x), 78);

    // Both buttons: standing, no motion.
    mv_if.left = 1'b1;
    edges(6);
    chk("both_moving", int'(mv_if.moving), 0);
    chk("both_x", int'(mv_if.mario_x), 78);

    // Reversal right -> left passes through one STANDING tick.
    mv_if.left = 1'b0;
    edges(3);
    chk("rev_pre_moving", int'(mv_if.moving), 1);
    mv_if.left  = 1'b1;
    mv_if.right = 1'b0;
    edges(1);
    chk("rev_standing", int'(mv_if.moving), 0);
    edges(1);
    chk("rev_moving", int'(mv_if.moving), 1);
    chk("rev_facing", int'(mv_if.facing_left), 1);
    edges(3);
    chk("rev_x_m3", int'(mv_if.mario_x), 78);
    edges(1);
    chk("rev_x_m4", int'(mv_if.mario_x), 77);

    // Left screen edge.
    wait_x(0, 400, "left_reach_0");
    wait_blk(10, "left_edge_blk");
    edges(1);
    chk("left_edge_blk_clear", int'(mv_if.blocked), 0);
    edges(3);
    chk("left_edge_blk_4", int'(mv_if.blocked), 1);
    chk("left_edge_x", int'(mv_if.mario_x), 0);
    chk("left_edge_facing", int'(mv_if.facing_left), 1);

    // Right screen edge on an open row.
    mv_if.background[9][3]  = SKY;
    mv_if.background[10][3] = SKY;
    mv_if.left  = 1'b0;
    mv_if.right = 1'b1;
    wait_x(598, 1500, "right_reach_598");
    wait_blk(10, "right_edge_blk");
    edges(4);
    chk("right_edge_blk_4", int'(mv_if.blocked), 1);
    chk("right_edge_x", int'(mv_if.mario_x), 598);
    chk("right_edge_facing", int'(mv_if.facing_left), 0);

    mv_if.right = 1'b0;
    edges(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mario_left_right_mover.md
Name: mario_left_right_mover

Overview:
- Horizontal counterpart to the vertical mover: owns mario_x and moves Mario left or right one pixel per step from the left/right buttons.
- Collides with solid tiles in the 12x17 background tile map and with the screen edges.
- Ramps speed from a slow to a fast step rate while a direction is held.
- Consumes mario_y from the vertical mover; mario_x is fed back to the vertical mover and the renderer.

Parameters:
- BDR, 0, border tile code
- SKY, 1, sky tile code
- BLK, 2, brick tile code
- GND, 3, ground tile code
- TKN, 4, token tile code
- CK1, 5, checkpoint tile code 1
- CK2, 6, checkpoint tile code 2
- CHARACTER_WIDTH, 42, Mario sprite width and height (pixels)
- SCREEN_WIDTH, 640, screen width (pixels)
- BLOCK_WIDTH, 40, tile edge (pixels)
- START_X, 40, mario_x after reset
- SLOW_PERIOD, 4, ticks per pixel step before acceleration
- FAST_PERIOD, 2, ticks per pixel step after acceleration
- ACCEL_STEPS, 8, pixel steps taken before switching to FAST_PERIOD

Ports:
- movement_clock  in  1  movement tick clock
- reset  in  1  asynchronous, active-low
- left  in  1  left button, level
- right  in  1  right button, level
- background  in  12x17 array of 8-bit  tile map, [row][col]
- mario_y  in  32 (int)  current Mario top-left y
- mario_x  out  32 (int)  Mario top-left x
- facing_left  out  1  sprite orientation
- moving  out  1  high in the MOVING_LEFT and MOVING_RIGHT states
- blocked  out  1  high for one tick when a due step was refused

Behaviour:
- Reset (async, reset=0):
  - mario_x=START_X, facing_left=0, moving=0, blocked=0.
  - state=RESET, div_cnt=0, step_cnt=0.
- States: RESET, STANDING, MOVING_LEFT, MOVING_RIGHT. Transitions occur on each movement_clock edge.
- Effective direction: dir_l = left & ~right; dir_r = right & ~left. Both pressed or neither pressed means no direction.
- RESET always goes to STANDING.
- STANDING:
  - dir_r goes to MOVING_RIGHT; dir_l goes to MOVING_LEFT; otherwise stay.
  - On entry to a moving state: div_cnt=0, step_cnt=0, facing_left updated (1 for left, 0 for right).
- MOVING_RIGHT:
  - If dir_r is not held, go to STANDING. This includes reversal, so reversing always passes through exactly one STANDING tick.
  - Otherwise stay; period = (step_cnt >= ACCEL_STEPS) ? FAST_PERIOD : SLOW_PERIOD.
  - If div_cnt == period-1, a step is due and div_cnt becomes 0; else div_cnt increments.
- MOVING_LEFT: mirror of MOVING_RIGHT.
- Due step, right:
  - Probe column cr = (mario_x + CHARACTER_WIDTH) / BLOCK_WIDTH.
  - Probe rows rt = (mario_y + 1) / BLOCK_WIDTH and rb = (mario_y + CHARACTER_WIDTH - 1) / BLOCK_WIDTH, each clamped to 11.
  - Refuse the step if background[rt][cr] or background[rb][cr] is BDR, BLK, GND, CK1 or CK2, or if mario_x >= SCREEN_WIDTH - CHARACTER_WIDTH.
- Due step, left:
  - Probe column cl = (mario_x - 1) / BLOCK_WIDTH, same rows.
  - Refuse the step if mario_x <= 0 or either probed tile is solid.
  - Never evaluate cl when mario_x = 0.
- Step accepted: mario_x ±1; step_cnt saturates at ACCEL_STEPS.
- Step refused: mario_x unchanged; step_cnt=0, so speed returns to slow; blocked=1 for that tick only.
- SKY and TKN are passable. Token collection is out of scope.
- Latency: press sampled at edge k enters the moving state. The first pixel moves at edge k+SLOW_PERIOD.
- Outputs are registered. mario_x never goes below 0 or above SCREEN_WIDTH-CHARACTER_WIDTH.
- Reset mid-move returns immediately to START_X with state RESET.

Decomposition:
- Package mario_pkg holds:
  - tile code constants (BDR..CK2), CHARACTER_WIDTH, BLOCK_WIDTH, SCREEN_WIDTH;
  - the direction-state enum;
  - a function is_solid(tile).
- One combinational sub-module, mario_side_probe:
  - inputs: background, mario_x, mario_y, side;
  - output: solid_ahead;
  - computes the probe column and the clamped rows.
- The FSM, divider and step counter stay in the top module.

Test Plan:
- Reset, all-SKY map -> mario_x=40, facing_left=0, moving=0, blocked=0; reset asserted mid-move -> mario_x returns to 40 without waiting for a clock edge.
- right held from edge k, SKY map -> mario_x=41 at edge k+4; 8 steps by edge k+32; then steps every 2 ticks, so mario_x=52 at edge k+40.
- BLK at [9][3] and [10][3], mario_y=360, mario_x=78, right held -> mario_x stays 78, blocked pulses at each due step, step_cnt stays 0.
- mario_x=0, left held -> mario_x stays 0, facing_left=1, blocked pulses every 4 ticks; mario_x=598, right held -> stays 598.
- left and right both held -> stays STANDING, mario_x unchanged.
- Reversal from MOVING_RIGHT to left only -> one STANDING tick, then MOVING_LEFT with facing_left=1 and slow speed: first left step 4 ticks after entering MOVING_LEFT.
